// File: rtl/selector_pkg.sv
// Shared types and helpers for the selector_n_pipe block.
// beat_t is sized for the widest supported configuration (BITS <= DATA_W_MAX,
// CHANNELS <= 16); each instance uses only the low bits of each field.
package selector_pkg;

    localparam int unsigned BEATCOUNT_W = 16;
    localparam int unsigned DATA_W_MAX  = 64;
    localparam int unsigned SEL_W_MAX   = 4;

    // One buffered beat: selected data, the select that chose it, and the range error.
    typedef struct packed {
        logic [DATA_W_MAX-1:0] data;
        logic [SEL_W_MAX-1:0]  sel;
        logic                  err;
    } beat_t;

    // Ceiling log2; clog2(1) is 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/selector_n_comb.sv
// Combinational N-way channel mux. An out-of-range select yields zero data and o_err=1.
module selector_n_comb #(
    parameter int unsigned BITS     = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_BITS = 2
) (
    input  logic [SEL_BITS-1:0]      i_sel,
    input  logic [CHANNELS*BITS-1:0] i_inputs,
    output logic [BITS-1:0]          o_data,
    output logic                     o_err
);

    // Pick the addressed channel; no match means the select is out of range.
    always_comb begin
        o_data = '0;
        o_err  = 1'b1;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (i_sel == SEL_BITS'(k)) begin
                o_data = i_inputs[k*BITS +: BITS];
                o_err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/selector_n_pipe.sv
// Registered channel selector with valid/ready handshakes on both sides.
// Optional macro SELECTOR_N_PIPE_SKID_EN adds a one-entry skid buffer so InReady
// comes straight from a flop; otherwise InReady is combinational from OutReady.
module selector_n_pipe
    import selector_pkg::*;
#(
    parameter int unsigned BITS     = 16,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned SEL_BITS = (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [SEL_BITS-1:0]      Sel,
    input  logic [CHANNELS*BITS-1:0] Inputs,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [BITS-1:0]          Output,
    output logic [SEL_BITS-1:0]      OutSel,
    output logic                     SelErr,
    output logic [BEATCOUNT_W-1:0]   BeatCount
);

    logic [BITS-1:0]        w_mux_data;
    logic                   w_mux_err;
    beat_t                  w_new_beat;
    logic                   w_in_ready;
    logic                   w_in_fire;
    logic                   w_out_fire;

    beat_t                  r_out;
    logic                   r_out_valid;
    beat_t                  w_out_next;
    logic                   w_out_valid_next;
    logic [BEATCOUNT_W-1:0] r_count;

    selector_n_comb #(
        .BITS     (BITS),
        .CHANNELS (CHANNELS),
        .SEL_BITS (SEL_BITS)
    ) u_mux (
        .i_sel    (Sel),
        .i_inputs (Inputs),
        .o_data   (w_mux_data),
        .o_err    (w_mux_err)
    );

    // Pack the incoming beat into the shared wide layout.
    always_comb begin
        w_new_beat                     = '0;
        w_new_beat.data[BITS-1:0]      = w_mux_data;
        w_new_beat.sel[SEL_BITS-1:0]   = Sel;
        w_new_beat.err                 = w_mux_err;
    end

    assign w_in_fire  = InValid && w_in_ready;
    assign w_out_fire = r_out_valid && OutReady;

`ifdef SELECTOR_N_PIPE_SKID_EN
    beat_t r_skid;
    logic  r_skid_valid;
    beat_t w_skid_next;
    logic  w_skid_valid_next;

    // Ready only depends on skid occupancy, breaking the OutReady->InReady path.
    assign w_in_ready = !r_skid_valid;

    // Output refills from the skid first to keep order; new beats park in the skid
    // while the output is stalled.
    always_comb begin
        w_out_next        = r_out;
        w_out_valid_next  = r_out_valid;
        w_skid_next       = r_skid;
        w_skid_valid_next = r_skid_valid;
        if (!r_out_valid || OutReady) begin
            if (r_skid_valid) begin
                w_out_next        = r_skid;
                w_out_valid_next  = 1'b1;
                w_skid_valid_next = 1'b0;
            end else if (w_in_fire) begin
                w_out_next       = w_new_beat;
                w_out_valid_next = 1'b1;
            end else begin
                w_out_valid_next = 1'b0;
            end
        end else if (w_in_fire) begin
            w_skid_next       = w_new_beat;
            w_skid_valid_next = 1'b1;
        end
    end

    // Skid buffer state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else begin
            r_skid       <= w_skid_next;
            r_skid_valid <= w_skid_valid_next;
        end
    end
`else
    // Accept whenever the output slot is empty or being emptied this cycle.
    assign w_in_ready = !r_out_valid || OutReady;

    // A new beat overwrites a departing one; otherwise a departure empties the slot.
    always_comb begin
        w_out_next       = r_out;
        w_out_valid_next = r_out_valid;
        if (w_in_fire) begin
            w_out_next       = w_new_beat;
            w_out_valid_next = 1'b1;
        end else if (w_out_fire) begin
            w_out_valid_next = 1'b0;
        end
    end
`endif

    // Output register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out       <= w_out_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    // Completed output transfers, wrapping at the counter width.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (w_out_fire) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign InReady   = w_in_ready;
    assign OutValid  = r_out_valid;
    assign Output    = r_out.data[BITS-1:0];
    assign OutSel    = r_out.sel[SEL_BITS-1:0];
    assign SelErr    = r_out.err;
    assign BeatCount = r_count;

    // Upper bits of the wide beat layout are constant zero here.
    logic w_unused;
    assign w_unused = ^{r_out.data >> BITS, r_out.sel >> SEL_BITS};

endmodule

// File: tb/tb_selector_n_pipe.sv
// Scoreboard bench for selector_n_pipe: stimulus pushes expected beats, negedge
// monitors pop/compare on each output transfer and check stability while stalled.
module tb_selector_n_pipe;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  sel;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  sel = '0;
    logic [63:0] inputs = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [1:0]  out_sel;
    logic        sel_err;
    logic [15:0] beat_count;

    logic        c3_in_valid = 1'b0;
    logic        c3_in_ready;
    logic [1:0]  c3_sel = '0;
    logic [47:0] c3_inputs = {16'h3002, 16'h3001, 16'h3000};
    logic        c3_out_valid;
    logic [15:0] c3_out_data;
    logic [1:0]  c3_out_sel;
    logic        c3_sel_err;
    logic [15:0] c3_beat_count;

    exp_t q[$];
    exp_t q3[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    selector_n_pipe #(.BITS(16), .CHANNELS(4)) u_dut (
        .Clk       (clk),
        .Reset     (rst),
        .InValid   (in_valid),
        .InReady   (in_ready),
        .Sel       (sel),
        .Inputs    (inputs),
        .OutValid  (out_valid),
        .OutReady  (out_ready),
        .Output    (out_data),
        .OutSel    (out_sel),
        .SelErr    (sel_err),
        .BeatCount (beat_count)
    );

    selector_n_pipe #(.BITS(16), .CHANNELS(3)) u_dut3 (
        .Clk       (clk),
        .Reset     (rst),
        .InValid   (c3_in_valid),
        .InReady   (c3_in_ready),
        .Sel       (c3_sel),
        .Inputs    (c3_inputs),
        .OutValid  (c3_out_valid),
        .OutReady  (1'b1),
        .Output    (c3_out_data),
        .OutSel    (c3_out_sel),
        .SelErr    (c3_sel_err),
        .BeatCount (c3_beat_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Main DUT monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got 0x%0h, expected no beat", out_data);
            end else if (out_ready) begin
                e = q.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_sel", 32'(out_sel), 32'(e.sel));
                check("sel_err", 32'(sel_err), 32'(e.err));
            end else begin
                check("hold_data", 32'(out_data), 32'(q[0].data));
                check("hold_sel", 32'(out_sel), 32'(q[0].sel));
            end
        end
    end

    // CHANNELS=3 DUT monitor (always ready downstream).
    always @(negedge clk) begin
        exp_t e;
        if (!rst && c3_out_valid) begin
            if (q3.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL c3_unexpected_beat: got 0x%0h, expected no beat", c3_out_data);
            end else begin
                e = q3.pop_front();
                check("c3_data", 32'(c3_out_data), 32'(e.data));
                check("c3_sel", 32'(c3_out_sel), 32'(e.sel));
                check("c3_err", 32'(c3_sel_err), 32'(e.err));
            end
        end
    end

    task automatic set_inputs(input logic [15:0] base);
        for (int k = 0; k < 4; k++) inputs[k*16 +: 16] = base + 16'(k);
    endtask

    // Offer one beat (channel k = base+k), push its expectation once accepted.
    task automatic send(input logic [15:0] base, input logic [1:0] s);
        int   n;
        exp_t e;
        n = 0;
        set_inputs(base);
        sel      = s;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
        end else begin
            e.data = base + 16'(s);
            e.sel  = s;
            e.err  = 1'b0;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(beat_count), 32'd0);
        rst = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic send3(input logic [1:0] s, input logic [15:0] d, input logic err);
        exp_t e;
        c3_sel      = s;
        c3_in_valid = 1'b1;
        #1;
        check("c3_in_ready", 32'(c3_in_ready), 32'd1);
        e.data = d;
        e.sel  = s;
        e.err  = err;
        q3.push_back(e);
        @(posedge clk);
        #1;
        c3_in_valid = 1'b0;
    endtask

    initial begin
        // Reset state.
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_output", 32'(out_data), 32'd0);
        check("reset_out_sel", 32'(out_sel), 32'd0);
        check("reset_sel_err", 32'(sel_err), 32'd0);
        check("reset_count", 32'(beat_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Basic select: Sel=2 -> 0x1002 one cycle after acceptance.
        out_ready = 1'b1;
        send(16'h1000, 2'd2);
        check("latency_valid", 32'(out_valid), 32'd1);
        wait_drain();
        check("basic_count", 32'(beat_count), 32'd1);

        // Stall: two beats offered while OutReady=0 for 5 cycles.
        out_ready = 1'b0;
        send(16'h5000, 2'd1);
        set_inputs(16'h6000);
        sel      = 2'd3;
        in_valid = 1'b1;
        @(negedge clk);
`ifdef SELECTOR_N_PIPE_SKID_EN
        check("stall_in_ready_skid", 32'(in_ready), 32'd1);
        q.push_back('{data: 16'h6003, sel: 2'd3, err: 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`else
        check("stall_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_in_ready_low", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
`ifndef SELECTOR_N_PIPE_SKID_EN
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        q.push_back('{data: 16'h6003, sel: 2'd3, err: 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`endif
        wait_drain();
        check("stall_count", 32'(beat_count), 32'd3);

        // Reset pulsed mid-stall: beat lost, count cleared immediately.
        out_ready = 1'b0;
        send(16'h7000, 2'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(beat_count), 32'd0);
        check("midrst_output", 32'(out_data), 32'd0);
        q.delete();
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_count_after", 32'(beat_count), 32'd0);

        // Out-of-range select on the 3-channel instance.
        send3(2'd3, 16'h0000, 1'b1);
        send3(2'd1, 16'h3001, 1'b0);
        send3(2'd2, 16'h3002, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("c3_left", 32'(q3.size()), 32'd0);
        check("c3_count", 32'(c3_beat_count), 32'd3);

        // Streaming 100 beats back-to-back.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) send(16'(16'h2000 + i * 4), 2'(i));
        wait_drain();
        check("stream_count", 32'(beat_count), 32'd100);

        // Counter wrap.
        do_reset();
        for (int i = 0; i < 65535; i++) send(16'(i), 2'(i));
        wait_drain();
        check("wrap_preload", 32'(beat_count), 32'h0000ffff);
        send(16'hABC0, 2'd1);
        wait_drain();
        check("wrap_count", 32'(beat_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
